// File: rtl/spi_master_ctrl_if.sv
// Host/pin bundle for the SPI master transaction controller.
// The master modport is the controller's view; slave is the host/pad side.
interface spi_master_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic [DIV_W-1:0]  div;
  logic              cpol;
  logic              cpha;
  logic              miso;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              sclk;
  logic              sclk_oe;
  logic              mosi;
  logic              cs_n;

  modport master (
    input  start, tx_data, div, cpol, cpha, miso,
    output busy, done, rx_data, sclk, sclk_oe, mosi, cs_n
  );

  modport slave (
    output start, tx_data, div, cpol, cpha, miso,
    input  busy, done, rx_data, sclk, sclk_oe, mosi, cs_n
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master transaction controller: one full-duplex MSB-first word per
// accepted start, with a counted burst of 2*DATA_W SCLK edges framed by a
// setup and hold interval of one half-period each.
module spi_master_ctrl #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  spi_master_ctrl_if.master bus
);

  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_HOLD
  } state_t;

  state_t            r_state;
  logic [DIV_W-1:0]  r_cnt;
  logic [DIV_W-1:0]  r_div;
  logic [EDGE_W-1:0] r_edge;
  logic              r_cpha;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_sclk;
  logic              r_sclk_oe;
  logic              r_mosi;
  logic              r_cs_n;

  logic              w_tick;
  logic [EDGE_W-1:0] w_edge;
  logic              w_sample;

  // Half-period tick, 1-based index of the edge about to be produced, and
  // whether that edge samples MISO (leading for CPHA=0, trailing for CPHA=1).
  assign w_tick   = (r_cnt == r_div);
  assign w_edge   = r_edge + 1'b1;
  assign w_sample = w_edge[0] ^ r_cpha;

  // Transfer sequencer: all pin and handshake outputs are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_div     <= '0;
      r_edge    <= '0;
      r_cpha    <= 1'b0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rx_data <= '0;
      r_sclk    <= 1'b0;
      r_sclk_oe <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs_n    <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_sclk    <= bus.cpol;
          r_sclk_oe <= 1'b0;
          r_cs_n    <= 1'b1;
          r_cnt     <= '0;
          r_edge    <= '0;
          if (bus.start) begin
            r_div     <= bus.div;
            r_cpha    <= bus.cpha;
            r_rx      <= '0;
            r_busy    <= 1'b1;
            r_cs_n    <= 1'b0;
            r_sclk_oe <= 1'b1;
            r_state   <= S_SETUP;
            // CPHA=0 needs the MSB on the wire before the first leading
            // edge; CPHA=1 presents it on that leading edge instead.
            if (!bus.cpha) begin
              r_mosi <= bus.tx_data[DATA_W-1];
              r_tx   <= {bus.tx_data[DATA_W-2:0], 1'b0};
            end else begin
              r_mosi <= 1'b0;
              r_tx   <= bus.tx_data;
            end
          end
        end

        S_SETUP: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_state <= S_XFER;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_XFER: begin
          if (w_tick) begin
            r_cnt  <= '0;
            r_edge <= w_edge;
            r_sclk <= ~r_sclk;
            if (w_sample) begin
              r_rx <= {r_rx[DATA_W-2:0], bus.miso};
            end else if (r_cpha || (w_edge != LAST_EDGE)) begin
              // No shift on the final trailing edge for CPHA=0: the last
              // bit must stay valid through the hold interval.
              r_mosi <= r_tx[DATA_W-1];
              r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
            end
            if (w_edge == LAST_EDGE) begin
              r_state <= S_HOLD;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_HOLD: begin
          if (w_tick) begin
            r_cnt     <= '0;
            r_state   <= S_IDLE;
            r_cs_n    <= 1'b1;
            r_sclk_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_rx_data <= r_rx;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.rx_data = r_rx_data;
  assign bus.sclk    = r_sclk;
  assign bus.sclk_oe = r_sclk_oe;
  assign bus.mosi    = r_mosi;
  assign bus.cs_n    = r_cs_n;

endmodule
